issue_scheduler: RTL



---
 rtl/issue_scheduler_if.sv | 55 +++++
 rtl/issue_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler_if.sv
// Issue-scheduler bus: everything between the decode stage, the scheduler and
// the ALU/load datapath except the clock and reset.
//
// Handshakes:
//   decode -> scheduler : an op transfers on a rising edge where iALLOC and oREADY
//                         are both high; iALLOC may be held while oREADY is low,
//                         and nothing transfers in that cycle.
//   scheduler -> units  : oISSUE_ALU / oISSUE_LOAD are one-cycle strobes with no
//                         back-pressure; the ids and ctrl are valid only with
//                         the strobe and read 0 otherwise.
//   load unit -> sched. : iLOAD_DONE is a one-cycle completion strobe.
//   sched. -> regfile   : oWB is a one-cycle strobe qualifying oWB_RD/oWB_SRC.
//
// Modports: slave = scheduler, master = decode/datapath side (or bench).
interface issue_sched_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          iALLOC;
  logic          oREADY;
  logic [3:0]    iALU_CTRL;
  logic [2:0]    iRS1;
  logic [2:0]    iRS2;
  logic [2:0]    iRD;
  logic          iEN_DEST;
  logic          iIS_ALU;
  logic          iIS_LOAD;
  logic          oISSUE_ALU;
  logic          oISSUE_LOAD;
  logic [3:0]    oALU_CTRL;
  logic [2:0]    oRS1;
  logic [2:0]    oRS2;
  logic [2:0]    oRD;
  logic          iLOAD_DONE;
  logic          oWB;
  logic [2:0]    oWB_RD;
  logic          oWB_SRC;
  logic [7:0]    oBUSY;
  logic [CW-1:0] oCOUNT;

  modport slave (
    input  iALLOC, iALU_CTRL, iRS1, iRS2, iRD, iEN_DEST, iIS_ALU, iIS_LOAD,
    input  iLOAD_DONE,
    output oREADY, oISSUE_ALU, oISSUE_LOAD, oALU_CTRL, oRS1, oRS2, oRD,
    output oWB, oWB_RD, oWB_SRC, oBUSY, oCOUNT
  );

  modport master (
    output iALLOC, iALU_CTRL, iRS1, iRS2, iRD, iEN_DEST, iIS_ALU, iIS_LOAD,
    output iLOAD_DONE,
    input  oREADY, oISSUE_ALU, oISSUE_LOAD, oALU_CTRL, oRS1, oRS2, oRD,
    input  oWB, oWB_RD, oWB_SRC, oBUSY, oCOUNT
  );
endinterface

// File: rtl/issue_scheduler.sv
// In-order issue controller for the 12-bit core.
// Decoded ops are buffered in a DEPTH-entry FIFO. The head op issues to the ALU
// or the load unit once its registers are free in the scoreboard. The single
// register-file writeback port is arbitrated between ALU results and load
// completions, with loads taking priority.
//
// Ports:
//   iCLK    clock, rising edge
//   iRST_N  asynchronous active-low reset; clears queue, scoreboard and outputs
//   bus     issue_sched_if.slave: decode handshake, issue strobes + ids,
//           load completion, writeback strobe, scoreboard and occupancy
module issue_scheduler #(
  parameter int DEPTH = 4,
  parameter int NREG  = 8
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  issue_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic       en_dest;
    logic       is_alu;
    logic       is_load;
  } op_t;

  // Queue storage and pointers
  op_t           mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Scoreboard and in-flight result tracking
  logic [NREG-1:0] busy_q, busy_d;
  logic            alu_pend_q, alu_pend_d;
  logic [2:0]      alu_rd_q, alu_rd_d;
  logic            load_out_q, load_out_d;
  logic [2:0]      load_rd_q, load_rd_d;

  // Registered outputs
  logic       issue_alu_q, issue_load_q;
  logic [3:0] ctrl_q;
  logic [2:0] rs1_q, rs2_q, rd_q;
  logic       wb_q, wb_src_q;
  logic [2:0] wb_rd_q;

  op_t  op_in;
  op_t  head;
  logic head_valid;
  logic ready;
  logic enq, deq;
  logic load_win, alu_win, alu_blocked;
  logic dest_busy;
  logic issue_alu, issue_load, drop;

  assign op_in = '{ctrl: bus.iALU_CTRL, rs1: bus.iRS1, rs2: bus.iRS2,
                   rd: bus.iRD, en_dest: bus.iEN_DEST, is_alu: bus.iIS_ALU,
                   is_load: bus.iIS_LOAD};

  // No pass-through: a full queue refuses ops even if the head leaves this cycle.
  assign ready      = (count_q != CW'(DEPTH));
  assign enq        = bus.iALLOC & ready;
  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);

  // A load completion only counts while a load is actually outstanding.
  assign load_win    = bus.iLOAD_DONE & load_out_q;
  assign alu_win     = alu_pend_q & ~load_win;
  assign alu_blocked = alu_pend_q & load_win;

  // Hazard checks use the registered scoreboard only.
  assign dest_busy  = head.en_dest & busy_q[head.rd];
  assign issue_alu  = head_valid & head.is_alu & ~busy_q[head.rs1] &
                      ~busy_q[head.rs2] & ~dest_busy & ~alu_blocked;
  assign issue_load = head_valid & ~head.is_alu & head.is_load &
                      ~busy_q[head.rs2] & ~dest_busy & ~load_out_q;
  // Ops aimed at neither unit are discarded without side effects.
  assign drop       = head_valid & ~head.is_alu & ~head.is_load;
  assign deq        = issue_alu | issue_load | drop;

  always_comb begin
    busy_d     = busy_q;
    alu_pend_d = alu_pend_q;
    alu_rd_d   = alu_rd_q;
    load_out_d = load_out_q;
    load_rd_d  = load_rd_q;

    if (load_win) begin
      busy_d[load_rd_q] = 1'b0;
      load_out_d        = 1'b0;
    end
    if (alu_win) begin
      busy_d[alu_rd_q] = 1'b0;
      alu_pend_d       = 1'b0;
    end
    // A new issue is applied last so its set wins over any clear above, and a
    // freshly issued ALU result replaces the one granted on the same edge.
    if ((issue_alu | issue_load) & head.en_dest) begin
      busy_d[head.rd] = 1'b1;
    end
    if (issue_alu & head.en_dest) begin
      alu_pend_d = 1'b1;
      alu_rd_d   = head.rd;
    end
    if (issue_load) begin
      load_out_d = 1'b1;
      load_rd_d  = head.rd;
    end
  end

  // Queue storage needs no reset: the pointers and count define validity.
  always_ff @(posedge iCLK) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= op_in;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      alu_pend_q   <= 1'b0;
      alu_rd_q     <= '0;
      load_out_q   <= 1'b0;
      load_rd_q    <= '0;
      issue_alu_q  <= 1'b0;
      issue_load_q <= 1'b0;
      ctrl_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      wb_q         <= 1'b0;
      wb_rd_q      <= '0;
      wb_src_q     <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(enq) - CW'(deq);

      busy_q     <= busy_d;
      alu_pend_q <= alu_pend_d;
      alu_rd_q   <= alu_rd_d;
      load_out_q <= load_out_d;
      load_rd_q  <= load_rd_d;

      issue_alu_q  <= issue_alu;
      issue_load_q <= issue_load;
      if (issue_alu | issue_load) begin
        ctrl_q <= head.ctrl;
        rs1_q  <= head.rs1;
        rs2_q  <= head.rs2;
        rd_q   <= head.rd;
      end else begin
        ctrl_q <= '0;
        rs1_q  <= '0;
        rs2_q  <= '0;
        rd_q   <= '0;
      end

      wb_q     <= load_win | alu_win;
      wb_src_q <= load_win;
      if (load_win)     wb_rd_q <= load_rd_q;
      else if (alu_win) wb_rd_q <= alu_rd_q;
      else              wb_rd_q <= '0;
    end
  end

  assign bus.oREADY      = ready;
  assign bus.oISSUE_ALU  = issue_alu_q;
  assign bus.oISSUE_LOAD = issue_load_q;
  assign bus.oALU_CTRL   = ctrl_q;
  assign bus.oRS1        = rs1_q;
  assign bus.oRS2        = rs2_q;
  assign bus.oRD         = rd_q;
  assign bus.oWB         = wb_q;
  assign bus.oWB_RD      = wb_rd_q;
  assign bus.oWB_SRC     = wb_src_q;
  assign bus.oBUSY       = busy_q;
  assign bus.oCOUNT      = count_q;
endmodule
